pcileech_sysctl_v2: RTL

//  Parametrised system-control block for PCILeech board tops. It replaces the ad-hoc tickcount/reset/LED

---
 rtl/pcileech_sysctl_v2.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/pcileech_sysctl_v2.sv
// pcileech_sysctl_v2: button sync/debounce, stretched system reset, long-press reload pulse, LED driver.
// Optional LED0 heartbeat after the power-on blink window: define PCILEECH_SYSCTL_HEARTBEAT_EN.
module pcileech_sysctl_v2 #(
    parameter int unsigned        NUM_BTN            = 2,
    parameter int unsigned        NUM_LED            = 2,
    parameter int unsigned        RST_BTN_IDX        = 1,
    parameter int unsigned        INV_BTN_IDX        = 0,
    parameter int unsigned        RST_STRETCH_CYCLES = 64,
    parameter int unsigned        DEBOUNCE_CYCLES    = 1000000,
    parameter int unsigned        LONGPRESS_CYCLES   = 500000000,
    parameter int unsigned        BLINK_BIT          = 24,
    parameter int unsigned        PWRON_BLINK_BITS   = 27,
    parameter logic [NUM_LED-1:0] PWRON_LED_MASK     = NUM_LED'(2'b10)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_BTN-1:0] btn_n,
    input  logic [NUM_LED-1:0] led_act,
    output logic [NUM_LED-1:0] led_n,
    output logic [NUM_BTN-1:0] btn_state,
    output logic               sys_rst,
    output logic               cfg_reload,
    output logic [63:0]        tickcount
);

    localparam int unsigned       DEB_W     = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned       HOLD_W    = $clog2(LONGPRESS_CYCLES + 1);
    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_FIRE = HOLD_W'(LONGPRESS_CYCLES - 1);

    typedef enum logic [1:0] {
        LP_IDLE  = 2'd0,
        LP_HELD  = 2'd1,
        LP_FIRED = 2'd2
    } lp_state_t;

    logic [NUM_BTN-1:0] sync_q1;
    logic [NUM_BTN-1:0] sync_q2;
    logic [NUM_BTN-1:0] btn_sync;
    logic               rst_btn;
    lp_state_t          lp_state;
    logic [HOLD_W-1:0]  hold_cnt;
    logic [HOLD_W-1:0]  hold_nxt;
    logic               pwron_window;
    logic               pwron;
    logic               inv;
    logic [NUM_LED-1:0] led_lit;

    // Two-flop synchroniser on the raw pads; released (1) out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q1 <= '1;
            sync_q2 <= '1;
        end else begin
            sync_q1 <= btn_n;
            sync_q2 <= sync_q1;
        end
    end

    assign btn_sync = ~sync_q2;

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_deb
        logic [DEB_W-1:0] cnt;
        logic             state;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt   <= '0;
                state <= 1'b0;
            end else if (btn_sync[g] == state) begin
                cnt <= '0;
            end else if (cnt == DEB_LAST) begin
                cnt   <= '0;
                state <= ~state;
            end else begin
                cnt <= cnt + DEB_W'(1);
            end
        end

        assign btn_state[g] = state;
    end

    assign rst_btn = btn_state[RST_BTN_IDX];

    // Holding the reset button parks tickcount at zero, so the stretch restarts on release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tickcount <= '0;
            sys_rst   <= 1'b1;
        end else begin
            tickcount <= rst_btn ? 64'd0 : tickcount + 64'd1;
            sys_rst   <= rst_btn | (tickcount < 64'(RST_STRETCH_CYCLES));
        end
    end

    assign hold_nxt = hold_cnt + HOLD_W'(1);

    // Long-press detector; the fire test uses the incremented count so the pulse lands
    // LONGPRESS_CYCLES clk after btn_state rises. Release always wins over firing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lp_state   <= LP_IDLE;
            hold_cnt   <= '0;
            cfg_reload <= 1'b0;
        end else begin
            cfg_reload <= 1'b0;
            case (lp_state)
                LP_IDLE: begin
                    if (rst_btn) begin
                        lp_state <= LP_HELD;
                        hold_cnt <= '0;
                    end
                end
                LP_HELD: begin
                    if (!rst_btn) begin
                        lp_state <= LP_IDLE;
                    end else begin
                        hold_cnt <= hold_nxt;
                        if (hold_nxt == HOLD_FIRE) begin
                            lp_state   <= LP_FIRED;
                            cfg_reload <= 1'b1;
                        end
                    end
                end
                LP_FIRED: begin
                    if (!rst_btn) begin
                        lp_state <= LP_IDLE;
                    end
                end
                default: lp_state <= LP_IDLE;
            endcase
        end
    end

    assign pwron_window = (tickcount[63:PWRON_BLINK_BITS] == '0);
    assign pwron        = tickcount[BLINK_BIT] & pwron_window;
    assign inv          = pwron ^ btn_state[INV_BTN_IDX];

`ifdef PCILEECH_SYSCTL_HEARTBEAT_EN
    logic hb_on;

    assign hb_on = (tickcount[BLINK_BIT+2:BLINK_BIT] == 3'b000);

    // After the power-on window LED0 shows activity OR a short heartbeat flash.
    always_comb begin
        led_lit = led_act ^ (PWRON_LED_MASK & {NUM_LED{inv}});
        if (!pwron_window) begin
            led_lit[0] = led_act[0] | hb_on;
        end
    end
`else
    always_comb begin
        led_lit = led_act ^ (PWRON_LED_MASK & {NUM_LED{inv}});
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led_n <= '1;
        end else begin
            led_n <= ~led_lit;
        end
    end

endmodule
